// File: rtl/resq_dispatch_ctrl.sv
// ResQ dispatch controller: pops the request manager head and assigns
// each request to the lowest free rescue team with a mission countdown.
module resq_dispatch_ctrl #(
  parameter int unsigned NUM_TEAMS = 4,
  parameter int unsigned TEAM_W    = 2,
  parameter int unsigned TIMER_W   = 8,
  parameter int unsigned FOOD_TIME = 20,
  parameter int unsigned SHEL_TIME = 40,
  parameter int unsigned EVAC_TIME = 60,
  parameter int unsigned PRIO_STEP = 5
) (
  input  logic                 Clock,
  input  logic                 Reset_Queue,
  input  logic                 Enable,
  input  logic                 Head_Valid,
  input  logic [1:0]           Head_Type,
  input  logic [7:0]           Head_Zone,
  input  logic [1:0]           Head_Priority,
  input  logic [NUM_TEAMS-1:0] Recall,
  output logic                 Serve,
  output logic                 Dispatch_Valid,
  output logic [TEAM_W-1:0]    Dispatch_Team,
  output logic [7:0]           Dispatch_Zone,
  output logic [1:0]           Dispatch_Type,
  output logic [NUM_TEAMS-1:0] Team_Busy,
  output logic                 All_Busy,
  output logic [15:0]          Dispatch_Count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam int unsigned TMAX =
    (32'd1 << TIMER_W) - 32'd1;

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q [NUM_TEAMS];
  logic [TIMER_W-1:0] timer_d [NUM_TEAMS];
  logic [TEAM_W-1:0]  team_q, team_d;
  logic [7:0]         zone_q, zone_d;
  logic [1:0]         type_q, type_d;
  logic [1:0]         prio_q, prio_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [TEAM_W-1:0]  free_idx;
  logic [TIMER_W-1:0] load_len;

  function automatic logic [TIMER_W-1:0] mission_len(
    input logic [1:0] t,
    input logic [1:0] p
  );
    int unsigned len;
    case (t)
      2'b00:   len = FOOD_TIME;
      2'b01:   len = SHEL_TIME;
      default: len = EVAC_TIME;
    endcase
    len = len + PRIO_STEP * 32'(p);
    if (len > TMAX) len = TMAX;
    return len[TIMER_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_TEAMS; i++) begin
      Team_Busy[i] = (timer_q[i] != '0);
    end
  end

  assign All_Busy = &Team_Busy;

  // Descending scan so the lowest free index wins
  always_comb begin
    free_idx = '0;
    for (int i = NUM_TEAMS - 1; i >= 0; i--) begin
      if (!Team_Busy[i]) free_idx = TEAM_W'(i);
    end
  end

  assign load_len = mission_len(type_q, prio_q);

  always_comb begin
    state_d        = state_q;
    team_d         = team_q;
    zone_d         = zone_q;
    type_d         = type_q;
    prio_d         = prio_q;
    cnt_d          = cnt_q;
    Serve          = 1'b0;
    Dispatch_Valid = 1'b0;
    for (int i = 0; i < NUM_TEAMS; i++) begin
      if (Recall[i])
        timer_d[i] = '0;
      else if (timer_q[i] != '0)
        timer_d[i] = timer_q[i] - 1'b1;
      else
        timer_d[i] = '0;
    end
    case (state_q)
      S_IDLE: begin
        if (Enable && Head_Valid &&
            Head_Type != 2'b11 && !All_Busy) begin
          team_d  = free_idx;
          zone_d  = Head_Zone;
          type_d  = Head_Type;
          prio_d  = Head_Priority;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Head gone before the pop: abandon quietly
        if (Head_Valid) begin
          Serve          = 1'b1;
          Dispatch_Valid = 1'b1;
          for (int i = 0; i < NUM_TEAMS; i++) begin
            if (TEAM_W'(i) == team_q)
              timer_d[i] = load_len;
          end
          if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
        end
        state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset_Queue) begin
      state_q <= S_IDLE;
      team_q  <= '0;
      zone_q  <= '0;
      type_q  <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_TEAMS; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      team_q  <= team_d;
      zone_q  <= zone_d;
      type_q  <= type_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NUM_TEAMS; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign Dispatch_Team  = team_q;
  assign Dispatch_Zone  = zone_q;
  assign Dispatch_Type  = type_q;
  assign Dispatch_Count = cnt_q;

endmodule

// File: tb/tb_resq_dispatch_ctrl.sv
// Bench for resq_dispatch_ctrl: directed vectors, corner sequences
// and a randomized run against a cycle-count reference model.
module tb_resq_dispatch_ctrl;

  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          hv;
  logic [1:0]    typ;
  logic [7:0]    zone;
  logic [1:0]    prio;
  logic [NT-1:0] recall;
  logic          Serve;
  logic          Dispatch_Valid;
  logic [1:0]    Dispatch_Team;
  logic [7:0]    Dispatch_Zone;
  logic [1:0]    Dispatch_Type;
  logic [NT-1:0] Team_Busy;
  logic          All_Busy;
  logic [15:0]   Dispatch_Count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  resq_dispatch_ctrl #(
    .NUM_TEAMS(4), .TEAM_W(2), .TIMER_W(8),
    .FOOD_TIME(20), .SHEL_TIME(40),
    .EVAC_TIME(250), .PRIO_STEP(5)
  ) dut (
    .Clock(clk),
    .Reset_Queue(rst),
    .Enable(en),
    .Head_Valid(hv),
    .Head_Type(typ),
    .Head_Zone(zone),
    .Head_Priority(prio),
    .Recall(recall),
    .Serve(Serve),
    .Dispatch_Valid(Dispatch_Valid),
    .Dispatch_Team(Dispatch_Team),
    .Dispatch_Zone(Dispatch_Zone),
    .Dispatch_Type(Dispatch_Type),
    .Team_Busy(Team_Busy),
    .All_Busy(All_Busy),
    .Dispatch_Count(Dispatch_Count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; hv = 1'b0;
    recall = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Mission length from the rules: base by type plus 5 per level, cap 255
  function automatic int mlen(input logic [1:0] t,
                              input logic [1:0] p);
    int l;
    l = (t == 2'b00) ? 20 : (t == 2'b01) ? 40 : 250;
    l = l + 5 * int'(p);
    return (l > 255) ? 255 : l;
  endfunction

  typedef struct {
    logic [1:0] t;
    logic [7:0] z;
    logic [1:0] p;
    int         len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int st[$];
    int tm[$];
    int exp_tm[5];
    int exp_gap[5];
    int nsrv;
    bit saw_all;
    int rem[NT];
    int acc, cyc, mcnt;
    logic [1:0] mteam, mtype, mprio;
    logic [7:0] mzone;

    #200_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int st[$];
    int tm[$];
    int exp_tm[5];
    int exp_gap[5];
    int nsrv;
    bit saw_all;
    int rem[NT];
    int acc, cyc, mcnt;
    bit issuing, accept, eall;
    logic [NT-1:0] ebusy;
    logic [1:0] mteam, mtype, mprio, nteam;
    logic [7:0] mzone;

    vecs[0] = '{2'b01, 8'h0C, 2'd1, 45};
    vecs[1] = '{2'b00, 8'h11, 2'd0, 20};
    vecs[2] = '{2'b00, 8'h22, 2'd3, 35};
    vecs[3] = '{2'b01, 8'h33, 2'd2, 50};
    vecs[4] = '{2'b10, 8'h44, 2'd0, 250};
    vecs[5] = '{2'b10, 8'h55, 2'd3, 255};
    vecs[6] = '{2'b11, 8'h66, 2'd1, 0};

    rst = 1'b1; en = 1'b1; hv = 1'b1;
    typ = 2'b00; zone = 8'h5A; prio = 2'd2;
    recall = 4'hF;

    // Reset with live head and recall pending
    repeat (2) @(negedge clk);
    chk("rst_serve", Serve, 0);
    chk("rst_dv", Dispatch_Valid, 0);
    chk("rst_busy", Team_Busy, 0);
    chk("rst_allbusy", All_Busy, 0);
    chk("rst_count", Dispatch_Count, 0);
    chk("rst_team", Dispatch_Team, 0);
    chk("rst_zone", Dispatch_Zone, 0);
    chk("rst_type", Dispatch_Type, 0);

    // Single dispatches: latency, fields, mission length
    for (int v = 0; v < 7; v++) begin
      do_reset();
      en = 1'b1; hv = 1'b1;
      typ = vecs[v].t; zone = vecs[v].z;
      prio = vecs[v].p;
      @(negedge clk);
      chk("vec_serve", Serve, vecs[v].len != 0);
      chk("vec_dv", Dispatch_Valid, vecs[v].len != 0);
      if (vecs[v].len != 0) begin
        chk("vec_team", Dispatch_Team, 0);
        chk("vec_zone", Dispatch_Zone, vecs[v].z);
        chk("vec_type", Dispatch_Type, vecs[v].t);
      end
      @(negedge clk);
      hv = 1'b0;
      chk("vec_busyvec", Team_Busy, vecs[v].len != 0);
      n = 0;
      for (int k = 0; k < 400; k++) begin
        if (Team_Busy == '0) break;
        n++;
        @(negedge clk);
      end
      chk("vec_len", n, vecs[v].len);
      chk("vec_count", Dispatch_Count, vecs[v].len != 0);
    end

    // Exhaust all teams, then reuse team 0 when it frees
    do_reset();
    en = 1'b1; hv = 1'b1;
    typ = 2'b10; zone = 8'h30; prio = 2'd0;
    exp_tm = '{0, 1, 2, 3, 0};
    exp_gap = '{0, 3, 6, 9, 252};
    saw_all = 1'b0;
    st.delete(); tm.delete();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (st.size() == 4 && All_Busy) saw_all = 1'b1;
      if (Serve) begin
        st.push_back(k);
        tm.push_back(int'(Dispatch_Team));
        if (st.size() == 5) break;
      end
    end
    @(negedge clk);
    hv = 1'b0;
    chk("exh_nserve", st.size(), 5);
    chk("exh_allbusy", saw_all, 1);
    for (int i = 0; i < st.size() && i < 5; i++) begin
      chk("exh_team", tm[i], exp_tm[i]);
      chk("exh_gap", st[i] - st[0], exp_gap[i]);
    end

    // Recall one team while all are out
    do_reset();
    en = 1'b1; hv = 1'b1;
    typ = 2'b10; zone = 8'h40; prio = 2'd0;
    nsrv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Serve) nsrv++;
      if (nsrv == 4) break;
    end
    @(negedge clk);
    hv = 1'b0;
    @(negedge clk);
    chk("rcl_allbusy", All_Busy, 1);
    recall = 4'b0100;
    @(negedge clk);
    recall = '0;
    chk("rcl_busyvec", Team_Busy, 4'b1011);
    hv = 1'b1;
    @(negedge clk);
    chk("rcl_serve", Serve, 1);
    chk("rcl_team", Dispatch_Team, 2);
    @(negedge clk);
    hv = 1'b0;
    chk("rcl_busyvec2", Team_Busy, 4'b1111);

    // Head drops during ISSUE, then Enable drops during ISSUE
    do_reset();
    en = 1'b1; hv = 1'b1;
    typ = 2'b00; zone = 8'h05; prio = 2'd0;
    @(negedge clk);
    hv = 1'b0;
    #1;
    chk("abt_serve", Serve, 0);
    chk("abt_dv", Dispatch_Valid, 0);
    @(negedge clk);
    chk("abt_count", Dispatch_Count, 0);
    @(negedge clk);
    chk("abt_busy", Team_Busy, 0);
    hv = 1'b1;
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("enoff_serve", Serve, 1);
    chk("enoff_team", Dispatch_Team, 0);
    @(negedge clk);
    hv = 1'b0;
    chk("enoff_count", Dispatch_Count, 1);
    chk("enoff_busy", Team_Busy, 4'b0001);

    // Randomized run against the reference model
    acc = -10; cyc = 0; mcnt = 0;
    mteam = '0; mzone = '0; mtype = '0; mprio = '0;
    for (int i = 0; i < NT; i++) rem[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst  = (c < 2);
      en   = ($urandom_range(7) != 0);
      hv   = ($urandom_range(3) != 0);
      typ  = 2'($urandom_range(3));
      zone = 8'($urandom);
      prio = 2'($urandom_range(3));
      for (int i = 0; i < NT; i++)
        recall[i] = ($urandom_range(31) == 0);
      #1;
      issuing = (cyc == acc + 1);
      for (int i = 0; i < NT; i++)
        ebusy[i] = (rem[i] != 0);
      eall = &ebusy;
      if (c >= 2) begin
        chk("rnd_serve", Serve, issuing && hv);
        chk("rnd_dv", Dispatch_Valid, issuing && hv);
        chk("rnd_busy", Team_Busy, ebusy);
        chk("rnd_allbusy", All_Busy, eall);
        chk("rnd_count", Dispatch_Count, mcnt);
        chk("rnd_team", Dispatch_Team, mteam);
        chk("rnd_zone", Dispatch_Zone, mzone);
        chk("rnd_type", Dispatch_Type, mtype);
      end
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NT; i++) rem[i] = 0;
        acc = -10; mcnt = 0;
        mteam = '0; mzone = '0; mtype = '0; mprio = '0;
      end else begin
        accept = (cyc != acc + 1) && (cyc != acc + 2) &&
                 en && hv && typ != 2'b11 && !eall;
        nteam = '0;
        for (int i = NT - 1; i >= 0; i--)
          if (rem[i] == 0) nteam = 2'(i);
        for (int i = 0; i < NT; i++)
          rem[i] = recall[i] ? 0 : (rem[i] > 0 ? rem[i] - 1 : 0);
        if (issuing && hv) begin
          rem[mteam] = mlen(mtype, mprio);
          if (mcnt < 65535) mcnt++;
        end
        if (accept) begin
          acc = cyc; mteam = nteam;
          mzone = zone; mtype = typ; mprio = prio;
        end
      end
      cyc++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
